// File: rtl/cms_pix28_scan_capture.sv
// Scan-chain capture: samples the ASIC scan_out a programmable delay after each shift-clock
// strobe into a 768-bit image and serves it as 24 x 32-bit words. Optional macro: CMS_PIX28_SCAN_CAPTURE_ONES_CNT_EN.
module cms_pix28_scan_capture #(
  parameter int unsigned SCAN_BITS = 768,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned DLY_W     = 6
) (
  input  logic              fw_axi_clk,
  input  logic              fw_rst_n,
  input  logic              cap_start,
  input  logic [DLY_W-1:0]  cap_sample_dly,
  input  logic              bxclk_rise,
  input  logic              scan_out,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              cap_overrun,
  input  logic              rd_req,
  input  logic [3:0]        rd_op_code,
  input  logic [3:0]        rd_word_idx,
  output logic              rd_ack,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_err
);

  localparam int unsigned CNT_W      = 10;
  localparam int unsigned SEL_W      = 5;
  localparam int unsigned HALF_WORDS = 12;
  localparam int unsigned LAST_BIT   = SCAN_BITS - 1;

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, DELAY, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               store_en;
  logic [SCAN_BITS-1:0] cap_mem_q;

  logic               rd_ack_q;
  logic [WORD_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_err_q, rd_err_d;
  logic               word_ok;
  logic               ones_sel;
  logic [SEL_W-1:0]   word_sel;
  logic [CNT_W-1:0]   rd_base;

  // Capture FSM next-state; cap_start restarts from any state and drops a pending sample
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    dly_d     = dly_q;
    dly_cnt_d = dly_cnt_q;
    overrun_d = overrun_q;
    store_en  = 1'b0;

    case (state_q)
      WAIT_EDGE: begin
        if (bxclk_rise) begin
          if (dly_q == '0) begin
            store_en = 1'b1;
          end else begin
            dly_cnt_d = dly_q;
            state_d   = DELAY;
          end
        end
      end
      DELAY: begin
        dly_cnt_d = dly_cnt_q - DLY_W'(1);
        if (bxclk_rise) overrun_d = 1'b1;
        if (dly_cnt_q == DLY_W'(1)) store_en = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    if (store_en) begin
      if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      state_d = (bit_cnt_q == CNT_W'(LAST_BIT)) ? DONE : WAIT_EDGE;
    end

    if (cap_start) begin
      state_d   = WAIT_EDGE;
      bit_cnt_d = '0;
      dly_d     = cap_sample_dly;
      dly_cnt_d = '0;
      overrun_d = 1'b0;
      store_en  = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      dly_q     <= '0;
      dly_cnt_q <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      dly_q     <= dly_d;
      dly_cnt_q <= dly_cnt_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      cap_mem_q <= '0;
    end else if (store_en) begin
      cap_mem_q[bit_cnt_q] <= scan_out;
    end
  end

`ifdef CMS_PIX28_SCAN_CAPTURE_ONES_CNT_EN
  logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;

  always_comb begin
    ones_cnt_d = ones_cnt_q + CNT_W'(store_en & scan_out);
    if (cap_start) ones_cnt_d = '0;
  end

  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) ones_cnt_q <= '0;
    else           ones_cnt_q <= ones_cnt_d;
  end
`endif

  // Read decode: 4'hC -> words 0..11, 4'hD -> words 12..23; anything else is an error
  always_comb begin
    word_ok   = 1'b0;
    ones_sel  = 1'b0;
    word_sel  = '0;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;

    case (rd_op_code)
      4'hC: begin
        if (rd_word_idx < 4'(HALF_WORDS)) begin
          word_ok  = 1'b1;
          word_sel = SEL_W'(rd_word_idx);
        end
      end
      4'hD: begin
        if (rd_word_idx < 4'(HALF_WORDS)) begin
          word_ok  = 1'b1;
          word_sel = SEL_W'(rd_word_idx) + SEL_W'(HALF_WORDS);
        end
`ifdef CMS_PIX28_SCAN_CAPTURE_ONES_CNT_EN
        else if (rd_word_idx == 4'(HALF_WORDS)) begin
          ones_sel = 1'b1;
        end
`endif
      end
      default: ;
    endcase

    rd_base = CNT_W'(32'(word_sel) * WORD_W);

    if (rd_req) begin
      rd_err_d = !(word_ok || ones_sel);
      if (word_ok) begin
        rd_data_d = cap_mem_q[rd_base +: WORD_W];
      end else begin
        rd_data_d = '0;
`ifdef CMS_PIX28_SCAN_CAPTURE_ONES_CNT_EN
        if (ones_sel) rd_data_d = WORD_W'(ones_cnt_q);
`endif
      end
    end
  end

  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_ack_q  <= rd_req;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign cap_busy    = busy_q;
  assign cap_done    = done_q;
  assign cap_overrun = overrun_q;
  assign rd_ack      = rd_ack_q;
  assign rd_data     = rd_data_q;
  assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_cms_pix28_scan_capture.sv
// Directed bench for cms_pix28_scan_capture: capture timing, overrun, restart, reset and read decode.
module tb_cms_pix28_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_start = 1'b0;
  logic [5:0]  cap_sample_dly = '0;
  logic        bxclk_rise = 1'b0;
  logic        scan_out = 1'b0;
  logic        cap_busy, cap_done, cap_overrun;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_op_code = '0;
  logic [3:0]  rd_word_idx = '0;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;

  cms_pix28_scan_capture dut (
    .fw_axi_clk     (clk),
    .fw_rst_n       (rst_n),
    .cap_start      (cap_start),
    .cap_sample_dly (cap_sample_dly),
    .bxclk_rise     (bxclk_rise),
    .scan_out       (scan_out),
    .cap_busy       (cap_busy),
    .cap_done       (cap_done),
    .cap_overrun    (cap_overrun),
    .rd_req         (rd_req),
    .rd_op_code     (rd_op_code),
    .rd_word_idx    (rd_word_idx),
    .rd_ack         (rd_ack),
    .rd_data        (rd_data),
    .rd_err         (rd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cap_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [3:0] op, input logic [3:0] idx, input logic [31:0] ed,
                    input logic ee, input string tag);
    rd_req = 1'b1; rd_op_code = op; rd_word_idx = idx;
    tick();
    rd_req = 1'b0;
    check({tag, "_ack"}, 32'(rd_ack), 32'd1);
    check({tag, "_data"}, rd_data, ed);
    check({tag, "_err"}, 32'(rd_err), 32'(ee));
  endtask

  task automatic start(input logic [5:0] dly);
    cap_start = 1'b1; cap_sample_dly = dly;
    tick();
    cap_start = 1'b0;
  endtask

  task automatic strobes(input int n, input logic val, input int gap);
    for (int i = 0; i < n; i++) begin
      bxclk_rise = 1'b1; scan_out = val;
      tick();
      bxclk_rise = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic delay_run(input int pos);
    start(6'd5);
    for (int i = 0; i < 32; i++) begin
      bxclk_rise = 1'b1; scan_out = 1'b0;
      tick();
      bxclk_rise = 1'b0;
      for (int k = 1; k < 8; k++) begin
        scan_out = (i == 0 && k == pos);
        tick();
      end
    end
    scan_out = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_busy", 32'(cap_busy), 32'd0);
    check("rst_done", 32'(cap_done), 32'd0);
    check("rst_ovr", 32'(cap_overrun), 32'd0);
    check("rst_ack", 32'(rd_ack), 32'd0);
    rst_n = 1'b1;
    tick();
    rd(4'hC, 4'd0, 32'h0, 1'b0, "rst_read");
    tick();
    check("ack_pulse", 32'(rd_ack), 32'd0);

    // Delay 0, alternating bits starting at 1
    start(6'd0);
    check("busy_rise", 32'(cap_busy), 32'd1);
    for (int i = 0; i < 768; i++) begin
      bxclk_rise = 1'b1; scan_out = (i % 2 == 0);
      tick();
      bxclk_rise = 1'b0;
      if (i == 767) begin
        check("alt_done", 32'(cap_done), 32'd1);
        check("alt_busy_in_done", 32'(cap_busy), 32'd1);
      end else begin
        tick();
      end
    end
    tick();
    check("alt_done_fall", 32'(cap_done), 32'd0);
    check("alt_busy_fall", 32'(cap_busy), 32'd0);
    for (int w = 0; w < 12; w++) begin
      rd(4'hC, 4'(w), 32'h5555_5555, 1'b0, "alt_c");
      rd(4'hD, 4'(w), 32'h5555_5555, 1'b0, "alt_d");
    end

    // Delay 5: sample lands exactly 5 cycles after strobe
    delay_run(5);
    rd(4'hC, 4'd0, 32'h0000_0001, 1'b0, "dly5_hit");
    rd(4'hC, 4'd1, 32'h5555_5555, 1'b0, "dly5_word1_kept");
    check("dly5_no_ovr", 32'(cap_overrun), 32'd0);
    delay_run(4);
    rd(4'hC, 4'd0, 32'h0000_0000, 1'b0, "dly4_miss");

    // Overrun: strobes 3 apart with delay 5 accept every other strobe
    start(6'd5);
    strobes(8, 1'b1, 3);
    check("ovr_set", 32'(cap_overrun), 32'd1);
    rd(4'hC, 4'd0, 32'h0000_000F, 1'b0, "ovr_word0");
    start(6'd0);
    check("ovr_clear", 32'(cap_overrun), 32'd0);

    // Restart at bit 100, then a full all-ones capture
    strobes(100, 1'b1, 2);
    done_base = done_cnt;
    start(6'd0);
    strobes(768, 1'b1, 2);
    tick(); tick();
    check("one_done", 32'(done_cnt - done_base), 32'd1);
    check("ones_busy", 32'(cap_busy), 32'd0);
    for (int w = 0; w < 12; w++) begin
      rd(4'hC, 4'(w), 32'hFFFF_FFFF, 1'b0, "ones_c");
      rd(4'hD, 4'(w), 32'hFFFF_FFFF, 1'b0, "ones_d");
    end
`ifdef CMS_PIX28_SCAN_CAPTURE_ONES_CNT_EN
    rd(4'hD, 4'd12, 32'd768, 1'b0, "ones_cnt");
`else
    rd(4'hD, 4'd12, 32'd0, 1'b1, "d12_illegal");
`endif

    // Illegal reads
    rd(4'hC, 4'd12, 32'd0, 1'b1, "c12_illegal");
    rd(4'h3, 4'd0, 32'd0, 1'b1, "op3_illegal");
    rd(4'hD, 4'd15, 32'd0, 1'b1, "d15_illegal");

    // Reset mid-capture
    done_base = done_cnt;
    start(6'd0);
    strobes(300, 1'b1, 2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(cap_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("rst_mid_busy2", 32'(cap_busy), 32'd0);
    check("rst_no_done", 32'(done_cnt - done_base), 32'd0);
    rd(4'hC, 4'd0, 32'd0, 1'b0, "rst_mem0");
    rd(4'hD, 4'd11, 32'd0, 1'b0, "rst_mem23");

    // Read on the same cycle as a store sees the old bit; back-to-back reads ack every cycle
    start(6'd0);
    bxclk_rise = 1'b1; scan_out = 1'b1;
    rd_req = 1'b1; rd_op_code = 4'hC; rd_word_idx = 4'd0;
    tick();
    bxclk_rise = 1'b0;
    check("same_cyc_ack", 32'(rd_ack), 32'd1);
    check("same_cyc_old", rd_data, 32'd0);
    tick();
    rd_req = 1'b0;
    check("b2b_ack", 32'(rd_ack), 32'd1);
    check("b2b_new", rd_data, 32'd1);
    tick();
    check("b2b_ack_end", 32'(rd_ack), 32'd0);
    check("data_hold", rd_data, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cms_pix28_scan_capture.md
# cms_pix28_scan_capture

Firmware-side reader for the 768-bit ASIC scan chain. While the scan chain is shifted, the block samples the serial `scan_out` bit from the ASIC a programmable number of cycles after each shift-clock rising edge and stores the bits. It then serves the stored image as 24 × 32-bit words in response to `OP_CODE_R_DATA_ARRAY_0` / `OP_CODE_R_DATA_ARRAY_1` reads from the command decoder. It sits beside the IP2 test2 sequencer, which drives `scan_in`, and its read port feeds the host read mux.

## Interface
- `SCAN_BITS`, default 768: scan-chain length; must equal 24 × `WORD_W`.
- `WORD_W`, default 32: read word width.
- `DLY_W`, default 6: width of the sample-delay field; matches the IP2 test_sample field.
- `fw_axi_clk`  in  1: single block clock (AXI 100 MHz).
- `fw_rst_n`  in  1: asynchronous, active-low reset.
- `cap_start`  in  1: one-cycle pulse; arms a new capture.
- `cap_sample_dly`  in  `DLY_W`: sample offset in clocks after `bxclk_rise`; latched on `cap_start`.
- `bxclk_rise`  in  1: one-cycle strobe per scan shift-clock rising edge, already in `fw_axi_clk` domain.
- `scan_out`  in  1: ASIC serial output, already synchronized.
- `cap_busy`  out  1: high from the cycle after `cap_start` until `cap_done`.
- `cap_done`  out  1: one-cycle pulse when the last bit has been stored.
- `cap_overrun`  out  1: sticky; a `bxclk_rise` arrived while a sample was still pending.
- `rd_req`  in  1: one-cycle read request.
- `rd_op_code`  in  4: op_code field of the read command word.
- `rd_word_idx`  in  4: body[3:0] of the read command word.
- `rd_ack`  out  1: one-cycle response strobe.
- `rd_data`  out  `WORD_W`: response data.
- `rd_err`  out  1: qualifies `rd_ack`; set on an illegal address or op code.

## Operation
- Storage: `cap_mem[SCAN_BITS-1:0]`. Bit 0 holds the first bit shifted out. Storage is not cleared by `cap_start`; it is cleared only by reset.
- The FSM has four states: IDLE, WAIT_EDGE, DELAY, DONE.
  - IDLE, on `cap_start`: set `bit_cnt`=0, latch the delay into `dly_q`, clear `cap_overrun`, go to WAIT_EDGE.
  - WAIT_EDGE, on `bxclk_rise`:
    - If `dly_q`==0: store `scan_out` at `bit_cnt` in the same cycle, then increment.
    - Otherwise: load `dly_cnt`=`dly_q` and go to DELAY.
  - DELAY: decrement `dly_cnt`. In the cycle it reaches 0, store `scan_out` at `bit_cnt`, increment `bit_cnt`, and return to WAIT_EDGE. The sample is therefore taken exactly `dly_q` cycles after the strobe.
  - A `bxclk_rise` received in DELAY sets `cap_overrun` and is otherwise ignored.
  - When the stored bit is number `SCAN_BITS`-1, go to DONE instead of WAIT_EDGE.
  - DONE: assert `cap_done` for one cycle, then go to IDLE.
  - `cap_start` in any non-IDLE state restarts the capture: same actions as from IDLE, and any pending sample is discarded.
- `bit_cnt` is 10 bits wide and saturates. It never wraps, because DONE is reached at count 767.
- Read decode:
  - `rd_op_code`=4'hC with idx 0..11 returns word idx.
  - `rd_op_code`=4'hD with idx 0..11 returns word idx+12.
  - Word n is `cap_mem[n*WORD_W +: WORD_W]`.
  - Any other op code, or idx > 11 (except the case in Configuration), gives `rd_data`=0 and `rd_err`=1.
- Reads are accepted in every state and never stall. A read during a capture returns the current partial contents.
- A read on the same cycle as a bit store returns the pre-store value of that bit.

## Timing
- Reset values: `cap_busy`, `cap_done`, `cap_overrun`, `rd_ack`, `rd_err` are 0; `rd_data`=0; `cap_mem`=0; FSM in IDLE.
- `cap_busy` rises 1 cycle after `cap_start` and falls in the cycle after the `cap_done` pulse.
- Read latency is 1 cycle: `rd_req` at cycle t gives `rd_ack`, `rd_data`, `rd_err` registered at t+1. `rd_data` holds its value until the next ack.
- Back-to-back `rd_req` on every cycle produces `rd_ack` on every cycle.
- Minimum `bxclk_rise` spacing without overrun is `dly_q`+1 cycles.
- Reset asserted mid-capture returns the block to reset values immediately; no `cap_done` is produced.

## Configuration
- `CMS_PIX28_SCAN_CAPTURE_ONES_CNT_EN`:
  - Defined: a 10-bit counter counts the `1` bits stored during the current capture. It clears on `cap_start`. `rd_op_code`=4'hD with idx 12 returns {22'b0, ones_cnt} with `rd_err`=0.
  - Undefined: the counter is absent, and idx 12 is illegal (`rd_err`=1, `rd_data`=0).

## Test plan
- Reset, then read 4'hC idx 0: response `rd_ack`=1, `rd_data`=0, `rd_err`=0 one cycle later.
- Delay 0, 768 strobes with alternating `scan_out` starting at 1: `cap_done` after the last strobe. Every word of 4'hC/4'hD idx 0..11 reads 32'h5555_5555.
- Delay 5, `scan_out` driven 1 only at strobe+5 for bit 0 (0 elsewhere): word 0 reads 32'h0000_0001. Repeating with the 1 at strobe+4 reads 0.
- Strobes 3 cycles apart with delay 5: `cap_overrun`=1 and `bit_cnt` advances once per two strobes. A following `cap_start` clears `cap_overrun`.
- `cap_start` at bit 100, then a full capture of all ones: all words read 32'hFFFF_FFFF and exactly one `cap_done` occurs. `fw_rst_n` pulsed at bit 300 of another capture: `cap_busy`=0, memory reads 0.
- Illegal reads (4'hC idx 12, 4'h3 idx 0) return `rd_err`=1. With the macro defined, 4'hD idx 12 after the all-ones capture returns 32'd768.
